chroni_line_scheduler: RTL and testbench
========================================

// Module: chroni_line_scheduler
// PURPOSE
//  Sys_clk-domain sequencer for the double-buffered scanline path of the chroni video output.
//  Consumes the synchronised frame_start/render_start/scanline_start/mode_changed pulses and pixel_scale.
//  Issues one render request per logical playfield line to the line renderer, alternating buffer halves (base 0 / LINE_WIDTH).
//  Flags overruns when the renderer falls behind the output.
// PARAMETERS
//  LINE_WIDTH  640  pixel offset of buffer half 1 in the 2*LINE_WIDTH-entry line buffer
//  Y_W         9    width of line number / line count
// PORTS
//  sys_clk         in   1    system clock; all logic on rising edge
//  reset           in   1    synchronous, active-high reset
//  frame_start     in   1    1-cycle pulse, start of VGA frame
//  render_start    in   1    1-cycle pulse, 3 lines before playfield
//  scanline_start  in   1    1-cycle pulse per VGA line
//  mode_changed    in   1    1-cycle pulse, VGA timing changed
//  pixel_scale     in   1    1 = 2x scaled mode (4 scanlines per buffer), 0 = 2 scanlines
//  cfg_lines       in   Y_W  logical lines per frame; sampled at render_start; 0 = render nothing
//  render_req      out  1    request a line render; held until render_ack
//  render_ack      in   1    1-cycle accept from renderer
//  render_done     in   1    1-cycle completion from renderer
//  render_line     out  Y_W  logical line number to render
//  render_buffer   out  1    target buffer half
//  render_base     out  11   0 or LINE_WIDTH, matches render_buffer
//  frame_active    out  1    high from render_start until last line done
//  overrun         out  1    1-cycle pulse: slot missed
//  stat_overruns   out  8    overrun count this frame (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, line_idx 0, phase 0, token 0.
//  FSM: IDLE -> REQ on render_start (cfg_lines!=0; latch cfg_lines, scale=pixel_scale, line_idx=0, phase=0, token=0).
//   REQ: render_req=1; on render_ack -> BUSY. BUSY: on render_done: if line_idx==lines-1 -> IDLE (frame_active=0);
//   else line_idx++, then if line_idx(new)==1 -> REQ (prefill) else -> WAIT. WAIT: when token=1, clear token -> REQ.
//  render_line=line_idx, render_buffer=line_idx[0], render_base=buffer?LINE_WIDTH:0; stable from req rise until done.
//  render_req rises the cycle after the transition into REQ; ack while req low is ignored.
//  Slot timer: active while frame_active; phase counts scanline_start modulo S (S=2 if scale=0, 4 if scale=1);
//   on wrap to 0 emits slot; slot sets token. Slot while token already 1 or FSM in REQ/BUSY for line>=2 -> overrun pulse, token stays 1.
//  render_start while frame_active: restart (as from IDLE); in-flight render -> DRAIN first, then restart.
//  mode_changed: abort; from REQ -> IDLE immediately (req drops); from BUSY -> DRAIN; DRAIN waits render_done -> IDLE.
//  Simultaneous render_done and slot in same cycle: both take effect (line advance, token set), no overrun.
//  frame_start: no FSM effect; clears stat counter only.
//  line_idx width Y_W, never wraps (terminates at lines-1).
// CONFIGURATION
//  CHRONI_SCHED_STATS_EN defined: stat_overruns counts overrun pulses, saturates at 255, cleared on frame_start/reset.
//  Not defined: stat_overruns tied to 0; no counter logic; overrun pulse still produced.
// STRUCTURE
//  chroni.vh: FSM state encodings (IDLE/REQ/BUSY/WAIT/DRAIN), SCALE_LINES_1X=2, SCALE_LINES_2X=4.
//  Sub-module chroni_slot_timer: phase counter + slot pulse (inputs: clk, reset, enable, scale, scanline_start).
// TESTING
//  cfg_lines=240, scale=0, renderer acks next cycle, done after 10 cycles -> lines 0,1 prefilled back to back, then one per 2 scanline_start; buffers 0,1,0,...; no overrun; frame_active falls after line 239 done.
//  scale=1, cfg_lines=270 -> one request per 4 scanline_start; render_base alternates 0/640; 270 requests total.
//  render_done delayed past 2 slots -> exactly one overrun pulse per missed extra slot; stat_overruns=count; frame_start clears to 0.
//  mode_changed during BUSY line 5 -> no new req; after render_done state IDLE, frame_active=0; next render_start restarts at line 0.
//  reset asserted in REQ -> next cycle render_req=0, frame_active=0, all outputs 0.
//  cfg_lines=0 at render_start -> no render_req, frame_active stays 0; build without CHRONI_SCHED_STATS_EN -> stat_overruns always 0.

Source files
------------

// File: rtl/chroni_line_scheduler_pkg.sv
// Shared types for the chroni scanline scheduler: FSM state encodings and
// scanlines-per-buffer constants for 1x and 2x pixel scaling.
package chroni_line_scheduler_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_BUSY  = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DRAIN = 3'd4
   } sched_state_t;

   localparam int SCALE_LINES_1X = 2;
   localparam int SCALE_LINES_2X = 4;

   // Phase value at which the next scanline_start closes a buffer slot.
   function automatic logic [1:0] slot_last(input logic scale);
      return scale ? 2'(SCALE_LINES_2X - 1) : 2'(SCALE_LINES_1X - 1);
   endfunction

endpackage

// File: rtl/chroni_slot_timer.sv
// Counts scanline_start pulses modulo 2 or 4 and emits a one-cycle slot pulse
// each time the count wraps; held at phase 0 while disabled.
module chroni_slot_timer
   import chroni_line_scheduler_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic scale,
   input  logic scanline_start,
   output logic slot
);

   logic [1:0] phase_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         phase_reg <= 2'd0;
         slot      <= 1'b0;
      end else begin
         slot <= 1'b0;
         if (!enable) begin
            phase_reg <= 2'd0;
         end else if (scanline_start) begin
            if (phase_reg == slot_last(scale)) begin
               phase_reg <= 2'd0;
               slot      <= 1'b1;
            end else begin
               phase_reg <= phase_reg + 2'd1;
            end
         end
      end
   end

endmodule

// File: rtl/chroni_line_scheduler.sv
// Double-buffered scanline render sequencer for chroni video output.
// Define CHRONI_SCHED_STATS_EN to enable the per-frame saturating overrun counter.
module chroni_line_scheduler
   import chroni_line_scheduler_pkg::*;
#(
   parameter int LINE_WIDTH = 640,
   parameter int Y_W        = 9
) (
   input  logic           sys_clk,
   input  logic           reset,
   input  logic           frame_start,
   input  logic           render_start,
   input  logic           scanline_start,
   input  logic           mode_changed,
   input  logic           pixel_scale,
   input  logic [Y_W-1:0] cfg_lines,
   output logic           render_req,
   input  logic           render_ack,
   input  logic           render_done,
   output logic [Y_W-1:0] render_line,
   output logic           render_buffer,
   output logic [10:0]    render_base,
   output logic           frame_active,
   output logic           overrun,
   output logic [7:0]     stat_overruns
);

   sched_state_t   state_reg;
   logic [Y_W-1:0] line_idx_reg;
   logic [Y_W-1:0] lines_reg;
   logic           scale_reg;
   logic           token_reg;
   logic           pend_reg;
   logic           render_req_reg;
   logic           frame_active_reg;
   logic           overrun_reg;

   logic           slot;
   logic           start_now;
   logic           abort;
   logic           late;
   logic           last_line;
   logic [Y_W-1:0] line_idx_next;

   chroni_slot_timer u_slot_timer (
      .clk            (sys_clk),
      .reset          (reset | start_now),
      .enable         (frame_active_reg),
      .scale          (scale_reg),
      .scanline_start (scanline_start),
      .slot           (slot)
   );

   always_comb begin
      line_idx_next = line_idx_reg + Y_W'(1);
      last_line     = (line_idx_next == lines_reg);
      abort         = mode_changed | (render_start & (cfg_lines == '0));
      start_now     = 1'b0;
      // A restart may begin at once unless a render is still in flight.
      if (render_start && !abort) begin
         case (state_reg)
            ST_IDLE, ST_WAIT:  start_now = 1'b1;
            ST_REQ:            start_now = !(render_req_reg && render_ack);
            ST_BUSY, ST_DRAIN: start_now = render_done;
            default:           start_now = 1'b0;
         endcase
      end
      if (!abort && state_reg == ST_DRAIN && pend_reg && render_done)
         start_now = 1'b1;
      // The two prefill lines never count as late.
      late = (line_idx_reg >= Y_W'(2)) &&
             ((state_reg == ST_REQ) || (state_reg == ST_BUSY && !render_done));
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state_reg        <= ST_IDLE;
         line_idx_reg     <= '0;
         lines_reg        <= '0;
         scale_reg        <= 1'b0;
         token_reg        <= 1'b0;
         pend_reg         <= 1'b0;
         render_req_reg   <= 1'b0;
         frame_active_reg <= 1'b0;
         overrun_reg      <= 1'b0;
      end else begin
         overrun_reg <= slot & (token_reg | late) & !start_now & !abort;
         if (start_now) begin
            state_reg        <= ST_REQ;
            render_req_reg   <= 1'b1;
            line_idx_reg     <= '0;
            lines_reg        <= cfg_lines;
            scale_reg        <= pixel_scale;
            token_reg        <= 1'b0;
            pend_reg         <= 1'b0;
            frame_active_reg <= 1'b1;
         end else if (abort) begin
            render_req_reg   <= 1'b0;
            frame_active_reg <= 1'b0;
            pend_reg         <= 1'b0;
            token_reg        <= 1'b0;
            case (state_reg)
               ST_REQ:            state_reg <= (render_req_reg && render_ack) ? ST_DRAIN : ST_IDLE;
               ST_BUSY, ST_DRAIN: state_reg <= render_done ? ST_IDLE : ST_DRAIN;
               default:           state_reg <= ST_IDLE;
            endcase
         end else if (render_start) begin
            // Renderer still owns a buffer: let it finish, then restart.
            render_req_reg   <= 1'b0;
            pend_reg         <= 1'b1;
            lines_reg        <= cfg_lines;
            scale_reg        <= pixel_scale;
            frame_active_reg <= 1'b1;
            state_reg        <= ST_DRAIN;
         end else begin
            case (state_reg)
               ST_REQ: begin
                  if (render_req_reg && render_ack) begin
                     render_req_reg <= 1'b0;
                     state_reg      <= ST_BUSY;
                  end
               end
               ST_BUSY: begin
                  if (render_done) begin
                     if (last_line) begin
                        state_reg        <= ST_IDLE;
                        frame_active_reg <= 1'b0;
                     end else begin
                        line_idx_reg <= line_idx_next;
                        if (line_idx_next == Y_W'(1)) begin
                           state_reg      <= ST_REQ;
                           render_req_reg <= 1'b1;
                        end else begin
                           state_reg <= ST_WAIT;
                        end
                     end
                  end
               end
               ST_WAIT: begin
                  if (token_reg) begin
                     token_reg      <= 1'b0;
                     state_reg      <= ST_REQ;
                     render_req_reg <= 1'b1;
                  end
               end
               ST_DRAIN: begin
                  if (render_done) begin
                     state_reg        <= ST_IDLE;
                     frame_active_reg <= 1'b0;
                  end
               end
               default: ;
            endcase
            if (slot)
               token_reg <= 1'b1;
         end
      end
   end

   assign render_req    = render_req_reg;
   assign render_line   = line_idx_reg;
   assign render_buffer = line_idx_reg[0];
   assign render_base   = line_idx_reg[0] ? 11'(LINE_WIDTH) : 11'd0;
   assign frame_active  = frame_active_reg;
   assign overrun       = overrun_reg;

`ifdef CHRONI_SCHED_STATS_EN
   logic [7:0] stat_reg;

   always_ff @(posedge sys_clk) begin
      if (reset || frame_start) begin
         stat_reg <= 8'd0;
      end else if (overrun_reg && stat_reg != 8'hFF) begin
         stat_reg <= stat_reg + 8'd1;
      end
   end

   assign stat_overruns = stat_reg;
`else
   logic unused_frame_start;
   assign unused_frame_start = frame_start;
   assign stat_overruns      = 8'd0;
`endif

endmodule

// File: tb/tb_chroni_line_scheduler.sv
// Scoreboard bench for chroni_line_scheduler: a frame model queues the expected
// render requests, an independent monitor pops and checks each handshake.
module tb_chroni_line_scheduler;

   localparam int LINE_W = 640;
   localparam int T      = 16;   // cycles between scanline_start pulses

   logic       sys_clk = 1'b0;
   logic       reset, frame_start, render_start, scanline_start, mode_changed, pixel_scale;
   logic [8:0] cfg_lines;
   logic       render_req, render_ack, render_done, render_buffer, frame_active, overrun;
   logic [8:0] render_line;
   logic [10:0] render_base;
   logic [7:0] stat_overruns;

   typedef struct {int line; int bufsel; int base;} exp_t;
   exp_t exp_q[$];

   int  checks = 0;
   int  errors = 0;
   int  ovr_seen = 0;
   int  req_cycles = 0;
   int  fa_cycles = 0;
   int  hs_line = -1;
   int  late_line = -1;
   int  late_lat = 0;
   bit  ack_block = 1'b0;

   chroni_line_scheduler #(.LINE_WIDTH(LINE_W), .Y_W(9)) dut (
      .sys_clk        (sys_clk),
      .reset          (reset),
      .frame_start    (frame_start),
      .render_start   (render_start),
      .scanline_start (scanline_start),
      .mode_changed   (mode_changed),
      .pixel_scale    (pixel_scale),
      .cfg_lines      (cfg_lines),
      .render_req     (render_req),
      .render_ack     (render_ack),
      .render_done    (render_done),
      .render_line    (render_line),
      .render_buffer  (render_buffer),
      .render_base    (render_base),
      .frame_active   (frame_active),
      .overrun        (overrun),
      .stat_overruns  (stat_overruns)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int stat_exp(input int n);
`ifdef CHRONI_SCHED_STATS_EN
      return (n > 255) ? 255 : n;
`else
      return 0;
`endif
   endfunction

   // Free-running VGA line timing.
   initial begin
      scanline_start = 1'b0;
      forever begin
         repeat (T - 1) tick();
         scanline_start = 1'b1;
         tick();
         scanline_start = 1'b0;
      end
   end

   // Renderer model: ack after 0..2 cycles, done after a short random latency.
   initial begin
      int d;
      int lat;
      render_ack  = 1'b0;
      render_done = 1'b0;
      forever begin
         tick();
         if (render_req && !ack_block && !reset) begin
            d = $urandom_range(0, 2);
            repeat (d) tick();
            if (render_req && !reset) begin
               lat = (int'(render_line) == late_line) ? late_lat : int'($urandom_range(2, 8));
               render_ack = 1'b1;
               tick();
               render_ack = 1'b0;
               repeat (lat - 1) tick();
               render_done = 1'b1;
               tick();
               render_done = 1'b0;
            end
         end
      end
   end

   // Monitor: every accepted request is compared against the head of the queue.
   always @(negedge sys_clk) begin
      if (!reset) begin
         if (overrun) ovr_seen++;
         if (render_req) req_cycles++;
         if (frame_active) fa_cycles++;
         if (render_req && render_ack) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_req: got line %0d expected no request", render_line);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               $display("req line=%0d buf=%0d base=%0d", render_line, render_buffer, render_base);
               check("req_line", 32'(render_line), e.line);
               check("req_buffer", 32'(render_buffer), e.bufsel);
               check("req_base", 32'(render_base), e.base);
               check("req_frame_active", 32'(frame_active), 1);
               hs_line = int'(render_line);
            end
         end
      end
   end

   task automatic pulse_frame_start();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic run_frame(input int n, input bit sc, input int ll, input int ld, input int exp_ovr);
      int budget;
      late_line = ll;
      late_lat  = ld;
      pulse_frame_start();
      cfg_lines   = 9'(n);
      pixel_scale = sc;
      for (int i = 0; i < n; i++) exp_q.push_back('{i, i % 2, (i % 2) * LINE_W});
      ovr_seen = 0;
      render_start = 1'b1;
      tick();
      render_start = 1'b0;
      @(negedge sys_clk);
      check("frame_active_rise", 32'(frame_active), 1);
      budget = n * (sc ? 4 : 2) * T + 400;
      while (frame_active && budget > 0) begin
         @(negedge sys_clk);
         budget--;
      end
      check("frame_end", 32'(frame_active), 0);
      check("reqs_left", exp_q.size(), 0);
      exp_q.delete();
      repeat (4) tick();
      check("overrun_pulses", ovr_seen, exp_ovr);
      check("stat_overruns", 32'(stat_overruns), stat_exp(exp_ovr));
      $display("frame lines=%0d scale=%0d overruns=%0d stat=%0d", n, sc, ovr_seen, stat_overruns);
      late_line = -1;
   endtask

   initial begin
      int budget;
      #1_500_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int budget;
      reset = 1'b1; frame_start = 1'b0; render_start = 1'b0; mode_changed = 1'b0;
      pixel_scale = 1'b0; cfg_lines = '0;
      repeat (3) tick();
      reset = 1'b0;
      @(negedge sys_clk);
      check("rst_req", 32'(render_req), 0);
      check("rst_frame_active", 32'(frame_active), 0);
      check("rst_line", 32'(render_line), 0);
      check("rst_base", 32'(render_base), 0);
      check("rst_overrun", 32'(overrun), 0);
      check("rst_stat", 32'(stat_overruns), 0);

      run_frame(240, 1'b0, -1, 0, 0);
      run_frame(270, 1'b1, -1, 0, 0);
      // Line 4 takes just over two slot periods: two missed slots.
      run_frame(12, 1'b0, 4, 66, 2);
      pulse_frame_start();
      @(negedge sys_clk);
      check("stat_cleared", 32'(stat_overruns), 0);

      for (int k = 0; k < 3; k++)
         run_frame(int'($urandom_range(3, 20)), 1'($urandom_range(0, 1)), -1, 0, 0);

      // Mode change while line 5 is being rendered.
      late_line = 5; late_lat = 20;
      pulse_frame_start();
      cfg_lines = 9'd20; pixel_scale = 1'b0;
      for (int i = 0; i < 20; i++) exp_q.push_back('{i, i % 2, (i % 2) * LINE_W});
      hs_line = -1;
      render_start = 1'b1; tick(); render_start = 1'b0;
      budget = 2000;
      while (hs_line != 5 && budget > 0) begin
         @(negedge sys_clk);
         budget--;
      end
      check("mode_reach_line5", hs_line, 5);
      tick(); tick();
      mode_changed = 1'b1; tick(); mode_changed = 1'b0;
      exp_q.delete();
      req_cycles = 0;
      @(negedge sys_clk);
      check("abort_frame_active", 32'(frame_active), 0);
      check("abort_req", 32'(render_req), 0);
      budget = 100;
      while (!render_done && budget > 0) begin
         @(negedge sys_clk);
         budget--;
      end
      check("abort_done_seen", 32'(render_done), 1);
      repeat (3 * 2 * T) tick();
      check("abort_no_req", req_cycles, 0);
      check("abort_idle", 32'(frame_active), 0);
      $display("mode_changed abort at line 5, req_cycles=%0d", req_cycles);
      late_line = -1;
      run_frame(6, 1'b0, -1, 0, 0);

      // Reset while a request is pending.
      ack_block = 1'b1;
      pulse_frame_start();
      cfg_lines = 9'd10;
      render_start = 1'b1; tick(); render_start = 1'b0;
      @(negedge sys_clk);
      check("req_before_reset", 32'(render_req), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge sys_clk);
      check("rst_req_dropped", 32'(render_req), 0);
      check("rst_fa_dropped", 32'(frame_active), 0);
      check("rst_line_zero", 32'(render_line), 0);
      check("rst_buffer_zero", 32'(render_buffer), 0);
      check("rst_base_zero", 32'(render_base), 0);
      $display("reset in REQ: req=%0d frame_active=%0d", render_req, frame_active);
      ack_block = 1'b0;

      // cfg_lines = 0 renders nothing.
      pulse_frame_start();
      cfg_lines = 9'd0;
      req_cycles = 0;
      fa_cycles = 0;
      render_start = 1'b1; tick(); render_start = 1'b0;
      repeat (100) tick();
      check("zero_lines_req", req_cycles, 0);
      check("zero_lines_active", fa_cycles, 0);
      check("zero_lines_stat", 32'(stat_overruns), 0);
      $display("cfg_lines=0: req_cycles=%0d active_cycles=%0d", req_cycles, fa_cycles);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
